// File: rtl/picomips_pkg.sv
// Shared opcodes, sequencer state encoding and opcode classification for the picoMips core.
package picomips_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] OP_NOP  = 3'b000;
  localparam logic [FUNC_W-1:0] OP_LSW  = 3'b001;
  localparam logic [FUNC_W-1:0] OP_ATR  = 3'b010;
  localparam logic [FUNC_W-1:0] OP_RTA  = 3'b011;
  localparam logic [FUNC_W-1:0] OP_ADD  = 3'b100;
  localparam logic [FUNC_W-1:0] OP_ADDI = 3'b101;
  localparam logic [FUNC_W-1:0] OP_MULI = 3'b110;
  localparam logic [FUNC_W-1:0] OP_HEI  = 3'b111;

  typedef enum logic [2:0] {IDLE, FETCH, READ, EXEC, WB, WAIT} state_t;

  // Opcodes whose result lands in the accumulator during EXEC.
  function automatic logic is_acc_op(input logic [FUNC_W-1:0] func);
    return (func == OP_RTA) || (func == OP_ADD) || (func == OP_ADDI) || (func == OP_MULI);
  endfunction

  // Opcodes that write the register file during WB.
  function automatic logic is_reg_op(input logic [FUNC_W-1:0] func);
    return (func == OP_ATR) || (func == OP_LSW);
  endfunction

endpackage

// File: rtl/picomips_sw_cond.sv
// SW[8] conditioning: 2-flop synchroniser, plus a stable-level debounce filter
// when PICOMIPS_SW_DEBOUNCE_EN is defined.
module picomips_sw_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic nReset,
  input  logic sw_i,
  output logic sw_o
);

  logic sync_q1;
  logic sync_q2;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("picomips_sw_cond: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw_i;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PICOMIPS_SW_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Output follows only after DEBOUNCE_CYCLES consecutive differing cycles; any reversion restarts the count.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
      sw_o  <= 1'b0;
    end else if (sync_q2 != sw_o) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        sw_o  <= sync_q2;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign sw_o = sync_q2;
`endif

endmodule

// File: rtl/picomips_phase_ctrl.sv
// picoMips multi-cycle sequencer: phase strobes, program counter, HEI wait and halt.
// Optional SW[8] debounce selected by PICOMIPS_SW_DEBOUNCE_EN.
module picomips_phase_ctrl
  import picomips_pkg::*;
#(
  parameter int unsigned PC_W            = 6,
  parameter int unsigned PROG_LEN        = 30,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [FUNC_W-1:0] func_i,
  input  logic              hei_arg_i,
  input  logic              sw8_i,
  input  logic              halt_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              fetch_en_o,
  output logic              rd_en_o,
  output logic              acc_we_o,
  output logic              reg_we_o,
  output logic              waiting_o,
  output logic              idle_o,
  output logic              sw8_sync_o
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_d;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return (pc == PC_LAST) ? '0 : pc + PC_W'(1);
  endfunction

  picomips_sw_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_cond (
    .Clock (Clock),
    .nReset(nReset),
    .sw_i  (sw8_i),
    .sw_o  (sw8_sync_o)
  );

  // Next state and PC; the PC moves only when leaving WB or a satisfied WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_o;
    case (state_q)
      IDLE:  if (!halt_i) state_d = FETCH;
      FETCH: state_d = READ;
      READ:  state_d = (func_i == OP_HEI) ? WAIT : EXEC;
      EXEC:  state_d = WB;
      WB: begin
        pc_d    = pc_next(pc_o);
        state_d = halt_i ? IDLE : FETCH;
      end
      WAIT: begin
        if (sw8_sync_o != hei_arg_i) begin
          pc_d    = pc_next(pc_o);
          state_d = halt_i ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered alongside the state so each is exactly the decode of the state being entered.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      pc_o       <= '0;
      fetch_en_o <= 1'b0;
      rd_en_o    <= 1'b0;
      acc_we_o   <= 1'b0;
      reg_we_o   <= 1'b0;
      waiting_o  <= 1'b0;
      idle_o     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_o       <= pc_d;
      fetch_en_o <= (state_d == FETCH);
      rd_en_o    <= (state_d == READ);
      acc_we_o   <= (state_d == EXEC) && is_acc_op(func_i);
      reg_we_o   <= (state_d == WB) && is_reg_op(func_i);
      waiting_o  <= (state_d == WAIT);
      idle_o     <= (state_d == IDLE);
    end
  end

  strobe_onehot0: assert property (@(posedge Clock) disable iff (!nReset)
    $onehot0({fetch_en_o, rd_en_o, acc_we_o, reg_we_o}));

endmodule

// File: tb/tb_picomips_phase_ctrl.sv
// Self-checking bench for picomips_phase_ctrl: directed tables, corner sequences and a random run against an instruction-level model.
module tb_picomips_phase_ctrl;
  import picomips_pkg::*;

  localparam int unsigned PC_W     = 6;
  localparam int unsigned PROG_LEN = 30;
  localparam int unsigned DB       = 16;
`ifdef PICOMIPS_SW_DEBOUNCE_EN
  localparam int unsigned DB_LAT   = DB;
  localparam int unsigned TOG_DIV  = 40;
`else
  localparam int unsigned DB_LAT   = 0;
  localparam int unsigned TOG_DIV  = 12;
`endif

  typedef struct packed {
    logic fetch;
    logic rd;
    logic acc;
    logic regw;
    logic wt;
    logic idle;
  } obs_t;

  localparam obs_t O_FETCH = 6'b100000;
  localparam obs_t O_READ  = 6'b010000;
  localparam obs_t O_ACC   = 6'b001000;
  localparam obs_t O_REGW  = 6'b000100;
  localparam obs_t O_WAIT  = 6'b000010;
  localparam obs_t O_IDLE  = 6'b000001;
  localparam obs_t O_NONE  = 6'b000000;

  typedef struct {
    logic [2:0]      func;
    logic            halt;
    obs_t            exp;
    logic [PC_W-1:0] pc;
  } vec_t;

  logic            Clock = 1'b0;
  logic            nReset = 1'b0;
  logic [2:0]      func_i = OP_NOP;
  logic            hei_arg_i = 1'b0;
  logic            sw8_i = 1'b0;
  logic            halt_i = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            fetch_en_o, rd_en_o, acc_we_o, reg_we_o, waiting_o, idle_o, sw8_sync_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  vec_t        vt [9];

  picomips_phase_ctrl #(
    .PC_W(PC_W), .PROG_LEN(PROG_LEN), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clock(Clock), .nReset(nReset), .func_i(func_i), .hei_arg_i(hei_arg_i),
    .sw8_i(sw8_i), .halt_i(halt_i), .pc_o(pc_o), .fetch_en_o(fetch_en_o),
    .rd_en_o(rd_en_o), .acc_we_o(acc_we_o), .reg_we_o(reg_we_o),
    .waiting_o(waiting_o), .idle_o(idle_o), .sw8_sync_o(sw8_sync_o)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    return obs_t'({fetch_en_o, rd_en_o, acc_we_o, reg_we_o, waiting_o, idle_o});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0; func_i = OP_NOP; halt_i = 1'b0; sw8_i = 1'b0; hei_arg_i = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  // ---- Instruction-level reference model ----
  obs_t            m_exp;
  obs_t            m_q[$];
  logic            m_hist[$];
  logic [PC_W-1:0] m_pc;
  logic            m_sync;
  bit              m_wait, m_adv;
  logic [2:0]      cur_f;
  logic            cur_hei;
`ifdef PICOMIPS_SW_DEBOUNCE_EN
  int unsigned     m_run;
`endif

  task automatic model_reset();
    m_q.delete();
    m_hist = '{1'b0, 1'b0, 1'b0};
    m_pc = '0; m_sync = 1'b0; m_wait = 1'b0; m_adv = 1'b0; m_exp = O_IDLE;
    cur_f = OP_NOP; cur_hei = 1'b0;
`ifdef PICOMIPS_SW_DEBOUNCE_EN
    m_run = 0;
`endif
  endtask

  // Called at each rising edge with the inputs that were held before it.
  task automatic model_step();
    logic s_before;
    s_before = m_sync;
    m_hist.push_front(sw8_i);
    void'(m_hist.pop_back());
`ifdef PICOMIPS_SW_DEBOUNCE_EN
    if (m_hist[2] != m_sync) begin
      m_run++;
      if (m_run == DB) begin m_sync = m_hist[2]; m_run = 0; end
    end else m_run = 0;
`else
    m_sync = m_hist[1];
`endif
    if (m_q.size() != 0) m_exp = m_q.pop_front();
    else if (m_wait && (s_before == cur_hei)) m_exp = O_WAIT;
    else begin
      if (m_wait || m_adv) m_pc = PC_W'((int'(m_pc) + 1) % PROG_LEN);
      m_wait = 1'b0; m_adv = 1'b0;
      if (halt_i) m_exp = O_IDLE;
      else begin
        m_exp   = O_FETCH;
        cur_f   = 3'($urandom_range(0, 7));
        cur_hei = 1'($urandom_range(0, 1));
        m_q.push_back(O_READ);
        if (cur_f == OP_HEI) begin
          m_q.push_back(O_WAIT);
          m_wait = 1'b1;
        end else begin
          m_q.push_back((cur_f inside {OP_RTA, OP_ADD, OP_ADDI, OP_MULI}) ? O_ACC : O_NONE);
          m_q.push_back((cur_f inside {OP_ATR, OP_LSW}) ? O_REGW : O_NONE);
          m_adv = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    logic prev_sync;

    // Reset, then back-to-back ADD instructions.
    vt = '{'{OP_ADD, 1'b0, O_FETCH, 6'd0}, '{OP_ADD, 1'b0, O_READ, 6'd0},
           '{OP_ADD, 1'b0, O_ACC,   6'd0}, '{OP_ADD, 1'b0, O_NONE, 6'd0},
           '{OP_ADD, 1'b0, O_FETCH, 6'd1}, '{OP_ADD, 1'b0, O_READ, 6'd1},
           '{OP_ADD, 1'b0, O_ACC,   6'd1}, '{OP_ADD, 1'b0, O_NONE, 6'd1},
           '{OP_ADD, 1'b0, O_FETCH, 6'd2}};
    do_reset();
    check("reset_obs", 32'(observe()), 32'(O_IDLE));
    check("reset_pc", 32'(pc_o), 32'd0);
    check("reset_sync", 32'(sw8_sync_o), 32'd0);
    for (int i = 0; i < 9; i++) begin
      func_i = vt[i].func; halt_i = vt[i].halt;
      step();
      check($sformatf("add_obs[%0d]", i), 32'(observe()), 32'(vt[i].exp));
      check($sformatf("add_pc[%0d]", i), 32'(pc_o), 32'(vt[i].pc));
    end

    // HEI wait with sw8 at the wait level; halt during the wait must not break it.
    func_i = OP_HEI; hei_arg_i = 1'b0; sw8_i = 1'b0;
    step(); check("hei_read", 32'(observe()), 32'(O_READ));
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      halt_i = (i >= 20 && i < 30);
      step();
      if (!waiting_o || pc_o != 6'd2) ok = 1'b0;
    end
    halt_i = 1'b0;
    check("hei_hold", 32'(ok), 32'd1);
    sw8_i = 1'b1;
    ok = 1'b1;
    for (int k = 1; k < int'(3 + DB_LAT); k++) begin
      step();
      if (!waiting_o || pc_o != 6'd2) ok = 1'b0;
    end
    check("hei_lat_hold", 32'(ok), 32'd1);
    func_i = OP_HEI;
    step();
    check("hei_exit_obs", 32'(observe()), 32'(O_FETCH));
    check("hei_exit_pc", 32'(pc_o), 32'd3);

    // HEI already satisfied: minimum 3-cycle instruction.
    step(); check("hei_min_read", 32'(observe()), 32'(O_READ));
    step(); check("hei_min_wait", 32'(observe()), 32'(O_WAIT));
    func_i = OP_NOP;
    step(); check("hei_min_fetch", 32'(observe()), 32'(O_FETCH));
    check("hei_min_pc", 32'(pc_o), 32'd4);

    // NOPs up to the last word, then LSW with wrap.
    ok = 1'b0; n = 0;
    while (!(fetch_en_o && pc_o == 6'(PROG_LEN - 1)) && n < 300) begin
      step();
      if (acc_we_o || reg_we_o) ok = 1'b1;
      n++;
    end
    check("nop_no_we", 32'(ok), 32'd0);
    check("reach_last_pc", 32'(fetch_en_o && pc_o == 6'(PROG_LEN - 1)), 32'd1);
    func_i = OP_LSW;
    step(); check("lsw_read", 32'(observe()), 32'(O_READ));
    step(); check("lsw_exec", 32'(observe()), 32'(O_NONE));
    step(); check("lsw_wb", 32'(observe()), 32'(O_REGW));
    check("lsw_wb_pc", 32'(pc_o), 32'(PROG_LEN - 1));
    step(); check("wrap_fetch", 32'(observe()), 32'(O_FETCH));
    check("wrap_pc", 32'(pc_o), 32'd0);

    // Halt raised in EXEC: ATR still writes back, then the sequencer parks.
    func_i = OP_ATR;
    step(); step();
    check("halt_exec", 32'(observe()), 32'(O_NONE));
    halt_i = 1'b1;
    step(); check("halt_wb", 32'(observe()), 32'(O_REGW));
    step(); check("halt_idle", 32'(observe()), 32'(O_IDLE));
    check("halt_pc", 32'(pc_o), 32'd1);
    ok = 1'b1;
    repeat (10) begin step(); if (!idle_o || pc_o != 6'd1) ok = 1'b0; end
    check("halt_frozen", 32'(ok), 32'd1);
    halt_i = 1'b0;
    step(); check("halt_release", 32'(observe()), 32'(O_FETCH));

    // Reset during EXEC of MULI.
    func_i = OP_MULI;
    step(); step();
    check("muli_exec", 32'(observe()), 32'(O_ACC));
    #2 nReset = 1'b0;
    #1;
    check("rst_mid_obs", 32'(observe()), 32'(O_IDLE));
    check("rst_mid_pc", 32'(pc_o), 32'd0);
    @(negedge Clock); @(negedge Clock);
    nReset = 1'b1;
    check("rst_release_obs", 32'(observe()), 32'(O_IDLE));
    step(); check("rst_first_fetch", 32'(observe()), 32'(O_FETCH));
    check("rst_first_pc", 32'(pc_o), 32'd0);

    // SW[8] conditioning latency (and glitch rejection when debounced).
    sw8_i = 1'b0;
    repeat (40) step();
    check("sync_low", 32'(sw8_sync_o), 32'd0);
`ifdef PICOMIPS_SW_DEBOUNCE_EN
    prev_sync = sw8_sync_o; ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) sw8_i = ~sw8_i;
      step();
      if (sw8_sync_o != prev_sync) ok = 1'b0;
    end
    sw8_i = 1'b0;
    repeat (4) begin step(); if (sw8_sync_o != prev_sync) ok = 1'b0; end
    check("glitch_reject", 32'(ok), 32'd1);
`else
    prev_sync = 1'b0;
`endif
    sw8_i = 1'b1; n = 0;
    while (sw8_sync_o == prev_sync && n < 100) begin step(); n++; end
    check("sync_rise_lat", 32'(n), 32'(2 + DB_LAT));

    // Random run against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clock);
      model_step();
      #1;
      check($sformatf("rand@%0d", cyc), 32'({observe(), pc_o, sw8_sync_o}),
            32'({m_exp, m_pc, m_sync}));
      func_i    = cur_f;
      hei_arg_i = cur_hei;
      halt_i    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, TOG_DIV - 1) == 0) sw8_i = ~sw8_i;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
